// File: rtl/twos_comp_accum_if.sv
// Handshake bundle between the sign-magnitude converter, the accumulator
// and the downstream consumer of the accumulated result.
interface twos_comp_accum_if #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_sat;
  logic              busy;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, busy
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_sat, busy
  );
endinterface

// File: rtl/twos_comp_accum.sv
// Saturating signed accumulator: sums N_SAMPLES two's complement words
// accepted over a valid/ready handshake, then holds the result until taken.
module twos_comp_accum #(
  parameter int DATA_W    = 4,
  parameter int ACC_W     = 8,
  parameter int N_SAMPLES = 4
) (
  input logic              clk,
  input logic              rst_n,
  twos_comp_accum_if.slave bus
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [ACC_W:0]   sum_w;
  logic [ACC_W-1:0] sum_clamped;
  logic             sum_ovf;

  // One extra bit of headroom exposes overflow as a mismatch of the top two bits
  always_comb begin
    sum_w = {acc_q[ACC_W-1], acc_q}
          + {{(ACC_W + 1 - DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
    sum_ovf     = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    sum_clamped = sum_w[ACC_W-1:0];
    if (sum_ovf) begin
      sum_clamped = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Next-state, accumulator, sample count and sticky saturation flag
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.in_valid) begin
          acc_d = sum_clamped;
          sat_d = sat_q | sum_ovf;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Handshake outputs decoded from the current state; result gated to DONE
  always_comb begin
    bus.in_ready  = (state_q == S_ACCUM);
    bus.out_valid = (state_q == S_DONE);
    bus.out_sum   = (state_q == S_DONE) ? acc_q : '0;
    bus.out_sat   = (state_q == S_DONE) & sat_q;
    bus.busy      = (state_q != S_IDLE);
  end

endmodule

// File: doc/twos_comp_accum.md
Name: twos_comp_accum

Overview:
- Sequential stage directly downstream of the 4-bit sign-magnitude to two's complement converter.
- Consumes a stream of 4-bit two's complement words through a valid/ready handshake.
- Accumulates a fixed number of samples into a saturating signed accumulator.
- Presents the final sum with a held-valid output handshake for the next stage.

Parameters:
- DATA_W, 4, input word width (two's complement).
- ACC_W, 8, accumulator and result width (two's complement); must be ≥ DATA_W.
- N_SAMPLES, 4, number of accepted words per accumulation; range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new accumulation; honoured only in IDLE.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  two's complement sample from the converter.
- in_ready  output  1  block will accept in_data this cycle.
- out_valid  output  1  out_sum/out_sat are valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  accumulated sum, two's complement.
- out_sat  output  1  sticky: saturation occurred during this accumulation.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset is asynchronous, active-low, with one clock. On rst_n low:
  - state = IDLE, acc = 0, count = 0, sat = 0.
  - in_ready = 0, out_valid = 0, out_sum = 0, out_sat = 0, busy = 0.
- States:
  - IDLE: in_ready = 0, out_valid = 0. start = 1 → clear acc, count and sat; next state ACCUM.
  - ACCUM: in_ready = 1. A transfer occurs when in_valid & in_ready at a clock edge. On a transfer:
    - sign-extend in_data to ACC_W and add to acc;
    - increment count.
    - When a transfer makes count == N_SAMPLES, next state is DONE in the same edge.
  - DONE: in_ready = 0, out_valid = 1. out_sum = acc and out_sat = sat, held stable until out_ready = 1 at a clock edge; then next state IDLE.
- Latency: out_valid rises on the edge that accepts the N_SAMPLES-th word, so the result is visible the cycle after the last transfer.
- Arithmetic:
  - Compute the sum at ACC_W+1 bits.
  - If the sum exceeds 2^(ACC_W-1)-1, clamp to that value (127 at defaults) and set sat.
  - If the sum is below -2^(ACC_W-1), clamp to that value (-128 at defaults) and set sat.
  - Saturation is evaluated per addition. Once set, sat stays set until the next start.
- Input 1000 (-8 at DATA_W=4) is accepted as -8. The converter never emits it for sign-magnitude -0, which arrives as 0000.
- start asserted in ACCUM or DONE is ignored. It does not restart, clear, or drop the pending result.
- start and out_ready both high in DONE: the result is consumed and the state goes to IDLE. start is not honoured that cycle; a new start is required in IDLE.
- in_valid while not in ACCUM: no transfer, no state change.
- Gaps in in_valid during ACCUM: acc and count hold.
- out_ready outside DONE: ignored.
- busy = (state != IDLE).
- rst_n asserted mid-accumulation or in DONE: immediate return to reset values. The pending result is lost and no out_valid pulse is produced.
- count width: ceil(log2(N_SAMPLES+1)) bits; count never wraps because accumulation stops at N_SAMPLES.

Test Plan:
- Basic sum, defaults:
  - Stimulus: start, then in_data 3, 5, -2 (1110), 1 with in_valid continuous.
  - Required: out_valid high the cycle after the 4th transfer, out_sum = 7 (00000111), out_sat = 0; out_valid held until out_ready, then IDLE.
- Positive saturation, ACC_W=4, N_SAMPLES=3:
  - Stimulus: 7, 7, 7.
  - Required: out_sum = 7 (0111), out_sat = 1.
- Negative saturation, ACC_W=4, N_SAMPLES=3:
  - Stimulus: -8, -8, 1.
  - Required: out_sum = -7 (1001), out_sat = 1 (sticky after the clamp at the 2nd add).
- Handshake gaps and backpressure, defaults:
  - Stimulus: in_valid toggled 1,0,1,0,1,1 with data 2, x, 2, x, 2, 2.
  - Required: exactly 4 transfers and out_sum = 8.
  - Then hold out_ready = 0 for 5 cycles: out_sum and out_valid stable, in_ready = 0, and extra in_valid pulses are not consumed.
- Ignored start and reset abort:
  - start pulsed mid-ACCUM after 2 words (1, 1): no clear; final out_sum with 1, 1 following = 4.
  - Separate run: rst_n low after 2 transfers → out_valid = 0, out_sum = 0, busy = 0 immediately, without waiting for a clock edge.
- Input -8 and back-to-back runs:
  - Stimulus: in_data 1000 ×4 at defaults.
  - Required: out_sum = -32 (11100000), out_sat = 0.
  - Then out_ready and a new start in the next IDLE cycle: acc cleared, second run of 0000 ×4 gives out_sum = 0 and out_sat = 0.
